train_detector: RTL and testbench

- Upstream stage of the level-crossing semaphore. Converts two raw, bouncy track sensors (A side and B side of the crossing section) into the clean "train present" level that drives the semaphore's clr/train input.
- Also reports travel direction and a fail-safe fault when a train enters the section but never leaves it.

---
 rtl/train_detector.sv | 156 +++++++++++++++
 tb/tb_train_detector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/train_detector.sv
// Track-sensor front end for the level-crossing semaphore: synchronizes and
// debounces the A/B wheel sensors, tracks a train through the section, and
// produces the train-present level, travel direction and a timeout fault.
module train_detector #(
   parameter int DEBOUNCE = 4,
   parameter int HOLD_CYC = 4,
   parameter int TIMEOUT  = 1000,
   parameter int CNT_W    = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sens_a,
   input  logic       sens_b,
   input  logic       fault_clr,
   output logic       train,
   output logic       dir,
   output logic       fault,
   output logic [2:0] state_dbg
);

   localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      OCC_AB  = 3'd1,
      OCC_BA  = 3'd2,
      EXIT_AB = 3'd3,
      EXIT_BA = 3'd4,
      HOLD    = 3'd5,
      FAULT   = 3'd6
   } state_t;

   // index 0 = A side, index 1 = B side
   logic [1:0]      s1;
   logic [1:0]      s2;
   logic [1:0]      db;
   logic [1:0]      db_d;
   logic [DB_W-1:0] dbc [2];
   logic [1:0]      rise;

   state_t          state;
   state_t          state_nx;
   logic            dir_nx;
   logic [CNT_W-1:0] cnt;
   logic            counting;

   // two-flop synchronizer for both raw sensors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {sens_b, sens_a};
         s2 <= s1;
      end
   end

   // per-sensor debounce: accept a new level only after DEBOUNCE steady cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db     <= '0;
         db_d   <= '0;
         dbc[0] <= '0;
         dbc[1] <= '0;
      end else begin
         db_d <= db;
         for (int unsigned i = 0; i < 2; i++) begin
            if (s2[i] == db[i]) begin
               dbc[i] <= '0;
            end else if (dbc[i] == DB_LAST) begin
               db[i]  <= s2[i];
               dbc[i] <= '0;
            end else begin
               dbc[i] <= dbc[i] + 1'b1;
            end
         end
      end
   end

   assign rise = db & ~db_d;

   // state register, direction register and shared timeout/hold counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         dir   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         dir   <= dir_nx;
         if (state_nx != state || !counting) begin
            cnt <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // next-state and direction decode; A wins a simultaneous entry
   always_comb begin
      state_nx = state;
      dir_nx   = dir;
      counting = 1'b0;
      case (state)
         IDLE: begin
            if (rise[0]) begin
               state_nx = OCC_AB;
               dir_nx   = 1'b0;
            end else if (rise[1]) begin
               state_nx = OCC_BA;
               dir_nx   = 1'b1;
            end
         end
         OCC_AB: begin
            counting = 1'b1;
            if (cnt == TO_LAST)   state_nx = FAULT;
            else if (rise[1])     state_nx = EXIT_AB;
         end
         OCC_BA: begin
            counting = 1'b1;
            if (cnt == TO_LAST)   state_nx = FAULT;
            else if (rise[0])     state_nx = EXIT_BA;
         end
         EXIT_AB, EXIT_BA: begin
            counting = 1'b1;
            if (cnt == TO_LAST)   state_nx = FAULT;
            else if (db == 2'b00) state_nx = HOLD;
         end
         HOLD: begin
            counting = 1'b1;
            // a following train re-occupies without ever dropping train
            if (rise[0]) begin
               state_nx = OCC_AB;
               dir_nx   = 1'b0;
            end else if (rise[1]) begin
               state_nx = OCC_BA;
               dir_nx   = 1'b1;
            end else if (cnt == HOLD_LAST) begin
               state_nx = IDLE;
            end
         end
         FAULT: begin
            if (fault_clr && db == 2'b00) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign train     = (state != IDLE);
   assign fault     = (state == FAULT);
   assign state_dbg = state;

endmodule

// File: tb/tb_train_detector.sv
// Scoreboard bench for train_detector: stimulus pushes time-stamped expected
// outputs, a negedge monitor pops and compares them when their cycle arrives.
module tb_train_detector;

   logic       clk;
   logic       rst_n;
   logic       sens_a;
   logic       sens_b;
   logic       fault_clr;
   logic       train;
   logic       dir;
   logic       fault;
   logic [2:0] state_dbg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int         due;
      logic [2:0] st;
      logic       tr;
      logic       dr;
      logic       fl;
      bit         cs;
      bit         cd;
      string      tag;
   } exp_t;

   exp_t sb[$];

   train_detector #(
      .DEBOUNCE(4),
      .HOLD_CYC(4),
      .TIMEOUT (64),
      .CNT_W   (10)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sens_a   (sens_a),
      .sens_b   (sens_b),
      .fault_clr(fault_clr),
      .train    (train),
      .dir      (dir),
      .fault    (fault),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle stamp: value n is visible from just after posedge n
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: compare every expectation whose cycle has arrived
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            total++;
            if (sb[i].due < cyc ||
                (sb[i].cs && state_dbg !== sb[i].st) ||
                train !== sb[i].tr ||
                (sb[i].cd && dir !== sb[i].dr) ||
                (sb[i].cs && fault !== sb[i].fl)) begin
               bad++;
               $display("FAIL %s cyc=%0d: got st=%0d train=%0b dir=%0b fault=%0b, want st=%0d train=%0b dir=%0b fault=%0b (due %0d)",
                        sb[i].tag, cyc, state_dbg, train, dir, fault,
                        sb[i].st, sb[i].tr, sb[i].dr, sb[i].fl, sb[i].due);
            end
            sb.delete(i);
         end
      end
   end

   task automatic expf(input int due, input logic [2:0] st, input logic tr,
                       input logic dr, input logic fl, input string tag);
      exp_t e;
      e.due = due; e.st = st; e.tr = tr; e.dr = dr; e.fl = fl;
      e.cs = 1'b1; e.cd = 1'b1; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic expt(input int due, input logic tr, input string tag);
      exp_t e;
      e.due = due; e.st = '0; e.tr = tr; e.dr = 1'b0; e.fl = 1'b0;
      e.cs = 1'b0; e.cd = 1'b0; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input string tag);
      expf(cyc, 3'd0, 1'b0, 1'b0, 1'b0, tag);
      rst_n = 1'b0;
      wait_until(cyc + 2);
      sens_a    = 1'b0;
      sens_b    = 1'b0;
      fault_clr = 1'b0;
      wait_until(cyc + 1);
      rst_n = 1'b1;
      wait_until(cyc + 2);
   endtask

   initial begin
      int t0, t1, t2, guard;
      rst_n = 1'b0; sens_a = 1'b0; sens_b = 1'b0; fault_clr = 1'b0;
      @(posedge clk);
      #1;
      do_reset("reset_state");

      // glitch of 3 raw cycles never gets through
      t0 = cyc;
      sens_a = 1'b1;
      for (int d = 1; d <= 12; d++) expf(t0 + d, 3'd0, 1'b0, 1'b0, 1'b0, "glitch_idle");
      wait_until(t0 + 3);
      sens_a = 1'b0;
      wait_until(t0 + 16);

      // A to B crossing: 0,1,3,5,0
      t0 = cyc;
      sens_a = 1'b1;
      expf(t0 + 6, 3'd0, 1'b0, 1'b0, 1'b0, "ab_pre");
      expf(t0 + 7, 3'd1, 1'b1, 1'b0, 1'b0, "ab_occ");
      wait_until(t0 + 10);
      t1 = cyc;
      sens_b = 1'b1;
      expf(t1 + 6, 3'd1, 1'b1, 1'b0, 1'b0, "ab_occ_hold");
      expf(t1 + 7, 3'd3, 1'b1, 1'b0, 1'b0, "ab_exit");
      wait_until(t0 + 20);
      sens_a = 1'b0;
      wait_until(t0 + 30);
      t2 = cyc;
      sens_b = 1'b0;
      expf(t2 + 6,  3'd3, 1'b1, 1'b0, 1'b0, "ab_exit_hold");
      expf(t2 + 7,  3'd5, 1'b1, 1'b0, 1'b0, "ab_hold");
      expf(t2 + 10, 3'd5, 1'b1, 1'b0, 1'b0, "ab_hold_last");
      expf(t2 + 11, 3'd0, 1'b0, 1'b0, 1'b0, "ab_idle");
      wait_until(t2 + 15);

      // B to A crossing: 0,2,4,5,0; dir stays 1 in IDLE afterwards
      t0 = cyc;
      sens_b = 1'b1;
      expf(t0 + 6, 3'd0, 1'b0, 1'b0, 1'b0, "ba_pre");
      expf(t0 + 7, 3'd2, 1'b1, 1'b1, 1'b0, "ba_occ");
      wait_until(t0 + 10);
      t1 = cyc;
      sens_a = 1'b1;
      expf(t1 + 7, 3'd4, 1'b1, 1'b1, 1'b0, "ba_exit");
      wait_until(t0 + 20);
      sens_b = 1'b0;
      wait_until(t0 + 30);
      t2 = cyc;
      sens_a = 1'b0;
      expf(t2 + 7,  3'd5, 1'b1, 1'b1, 1'b0, "ba_hold");
      expf(t2 + 11, 3'd0, 1'b0, 1'b1, 1'b0, "ba_idle");
      expf(t2 + 14, 3'd0, 1'b0, 1'b1, 1'b0, "ba_dir_kept");
      wait_until(t2 + 15);

      // simultaneous rise: A priority; then reset while occupied
      t0 = cyc;
      sens_a = 1'b1;
      sens_b = 1'b1;
      expf(t0 + 6, 3'd0, 1'b0, 1'b1, 1'b0, "both_pre");
      expf(t0 + 7, 3'd1, 1'b1, 1'b0, 1'b0, "both_occ_ab");
      wait_until(t0 + 10);
      sens_a = 1'b0;
      sens_b = 1'b0;
      expf(t0 + 19, 3'd1, 1'b1, 1'b0, 1'b0, "both_still_occ");
      wait_until(t0 + 20);
      do_reset("reset_occ");

      // timeout fault, ignored clear, accepted clear
      t0 = cyc;
      sens_a = 1'b1;
      expf(t0 + 7,  3'd1, 1'b1, 1'b0, 1'b0, "to_occ");
      expf(t0 + 70, 3'd1, 1'b1, 1'b0, 1'b0, "to_last_occ");
      expf(t0 + 71, 3'd6, 1'b1, 1'b0, 1'b1, "to_fault");
      wait_until(t0 + 75);
      fault_clr = 1'b1;
      wait_until(t0 + 76);
      fault_clr = 1'b0;
      expf(t0 + 77, 3'd6, 1'b1, 1'b0, 1'b1, "clr_ignored");
      wait_until(t0 + 78);
      sens_a = 1'b0;
      expf(t0 + 90, 3'd6, 1'b1, 1'b0, 1'b1, "fault_held");
      wait_until(t0 + 90);
      fault_clr = 1'b1;
      expf(t0 + 91, 3'd0, 1'b0, 1'b0, 1'b0, "clr_idle");
      wait_until(t0 + 91);
      fault_clr = 1'b0;
      wait_until(t0 + 96);

      // back-to-back: B-side train arrives during HOLD of an A-to-B train
      t0 = cyc;
      sens_a = 1'b1;
      expf(t0 + 7, 3'd1, 1'b1, 1'b0, 1'b0, "b2b_occ_ab");
      for (int d = 7; d <= 39; d++) expt(t0 + d, 1'b1, "b2b_train_high");
      wait_until(t0 + 10);
      sens_b = 1'b1;
      expf(t0 + 17, 3'd3, 1'b1, 1'b0, 1'b0, "b2b_exit");
      wait_until(t0 + 15);
      sens_b = 1'b0;
      wait_until(t0 + 25);
      sens_a = 1'b0;
      expf(t0 + 31, 3'd3, 1'b1, 1'b0, 1'b0, "b2b_exit_hold");
      expf(t0 + 32, 3'd5, 1'b1, 1'b0, 1'b0, "b2b_hold");
      wait_until(t0 + 28);
      sens_b = 1'b1;
      expf(t0 + 34, 3'd5, 1'b1, 1'b0, 1'b0, "b2b_hold2");
      expf(t0 + 35, 3'd2, 1'b1, 1'b1, 1'b0, "b2b_occ_ba");
      expf(t0 + 39, 3'd2, 1'b1, 1'b1, 1'b0, "b2b_pre_rst");
      wait_until(t0 + 40);
      do_reset("reset_mid");

      guard = 0;
      while (sb.size() > 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
         total += sb.size();
         bad   += sb.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
